status_led_arbiter: RTL and testbench

- Shares the board's red/green front-panel LED pair between four status sources: ADC overrange, DAC overrange, PLL unlock and TX active.
- Stretches short clip pulses, then grants the LED to the highest-priority pending source.
- Enforces a minimum display time per owner.
- Generates a distinct steady/blink pattern per owner.
- Sits in the slow housekeeping domain (slow_clock, 100 kHz, 10 us tick) beside the other indicator logic.

---
 rtl/status_led_arbiter.sv | 131 +++++++++++++
 tb/tb_status_led_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/status_led_arbiter.sv
// Front-panel red/green LED arbiter: stretches ADC/DAC clip pulses, grants the LED
// pair to the highest-priority source with a minimum hold, and drives a per-owner pattern.
module status_led_arbiter #(
  parameter int TIMER_W    = 16,
  parameter int HOLD_CLIP  = 20000,
  parameter int HOLD_MIN   = 5000,
  parameter int BLINK_HALF = 25000
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       adc_overrange,
  input  logic       dac_overrange,
  input  logic       pll_locked,
  input  logic       tx_active,
  output logic       led_red,
  output logic       led_green,
  output logic [2:0] active_src
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADC  = 3'd1;
  localparam logic [2:0] S_DAC  = 3'd2;
  localparam logic [2:0] S_PLL  = 3'd3;
  localparam logic [2:0] S_TX   = 3'd4;

  localparam logic [TIMER_W-1:0] CLIP_LOAD  = TIMER_W'(HOLD_CLIP);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_MIN - 1);
  localparam logic [TIMER_W-1:0] BLINK_MID  = TIMER_W'(BLINK_HALF);
  localparam logic [TIMER_W-1:0] BLINK_LAST = TIMER_W'(2 * BLINK_HALF - 1);

  logic [1:0]         clip_in;
  logic [TIMER_W-1:0] clip_timer [2];
  logic [3:0]         req;

  logic [2:0]         state_reg;
  logic [2:0]         state_next;
  logic [2:0]         top_src;
  logic               higher_pending;
  logic               own_req;
  logic [TIMER_W-1:0] hold_reg;
  logic [TIMER_W-1:0] blink_reg;
  logic               phase_a;

  assign clip_in = {dac_overrange, adc_overrange};

  // Retriggerable stretchers: any high sample reloads to full, otherwise count down to 0.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_clip
      always_ff @(posedge slow_clock) begin
        if (reset) begin
          clip_timer[gi] <= '0;
        end else if (clip_in[gi]) begin
          clip_timer[gi] <= CLIP_LOAD;
        end else if (clip_timer[gi] != '0) begin
          clip_timer[gi] <= clip_timer[gi] - 1'b1;
        end
      end
      assign req[gi] = (clip_timer[gi] != '0);
    end
  endgenerate

  assign req[2] = ~pll_locked;
  assign req[3] = tx_active;

  // Later assignments win, so ADC ends up with the highest priority.
  always_comb begin
    top_src = S_IDLE;
    if (req[3]) top_src = S_TX;
    if (req[2]) top_src = S_PLL;
    if (req[1]) top_src = S_DAC;
    if (req[0]) top_src = S_ADC;
  end

  always_comb begin
    higher_pending = 1'b0;
    own_req        = 1'b0;
    case (state_reg)
      S_ADC: begin higher_pending = 1'b0;      own_req = req[0]; end
      S_DAC: begin higher_pending = req[0];    own_req = req[1]; end
      S_PLL: begin higher_pending = |req[1:0]; own_req = req[2]; end
      S_TX:  begin higher_pending = |req[2:0]; own_req = req[3]; end
      default: begin higher_pending = 1'b0;    own_req = 1'b0;   end
    endcase
  end

  // Preemption ignores the hold; a released owner only yields once the hold has elapsed.
  always_comb begin
    state_next = state_reg;
    if (state_reg == S_IDLE || higher_pending || (!own_req && hold_reg >= HOLD_LAST)) begin
      state_next = top_src;
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      hold_reg  <= '0;
      blink_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        hold_reg  <= '0;
        blink_reg <= '0;
      end else begin
        hold_reg  <= (hold_reg >= HOLD_LAST) ? HOLD_LAST : hold_reg + 1'b1;
        blink_reg <= (blink_reg == BLINK_LAST) ? '0 : blink_reg + 1'b1;
      end
    end
  end

  assign phase_a = (blink_reg < BLINK_MID);

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      led_red    <= 1'b0;
      led_green  <= 1'b0;
      active_src <= S_IDLE;
    end else begin
      active_src <= state_reg;
      case (state_reg)
        S_ADC:   begin led_red <= 1'b1;    led_green <= 1'b0;     end
        S_DAC:   begin led_red <= phase_a; led_green <= 1'b0;     end
        S_PLL:   begin led_red <= phase_a; led_green <= ~phase_a; end
        S_TX:    begin led_red <= 1'b1;    led_green <= 1'b1;     end
        default: begin led_red <= 1'b0;    led_green <= 1'b0;     end
      endcase
    end
  end

endmodule

// File: tb/tb_status_led_arbiter.sv
// Directed bench for status_led_arbiter with short timers; outputs are packed as
// {red, green, active_src} and compared against hand-derived cycle expectations.
module tb_status_led_arbiter;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic       adc_overrange;
  logic       dac_overrange;
  logic       pll_locked;
  logic       tx_active;
  logic       led_red;
  logic       led_green;
  logic [2:0] active_src;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] IDLE  = 5'b00_000;
  localparam logic [4:0] ADC   = 5'b10_001;
  localparam logic [4:0] AMBER = 5'b11_100;

  status_led_arbiter #(
    .TIMER_W(16), .HOLD_CLIP(20), .HOLD_MIN(5), .BLINK_HALF(4)
  ) dut (
    .slow_clock(slow_clock),
    .reset(reset),
    .adc_overrange(adc_overrange),
    .dac_overrange(dac_overrange),
    .pll_locked(pll_locked),
    .tx_active(tx_active),
    .led_red(led_red),
    .led_green(led_green),
    .active_src(active_src)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b required=%b", tag, got, exp);
    end else begin
      $display("ok   %s %b", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {led_red, led_green, active_src};
  endfunction

  function automatic logic [4:0] dac_pat(input int j);
    return {((j % 8) < 4) ? 1'b1 : 1'b0, 1'b0, 3'd2};
  endfunction

  function automatic logic [4:0] pll_pat(input int j);
    logic a;
    a = ((j % 8) < 4);
    return {a, ~a, 3'd3};
  endfunction

  initial begin
    // 1: reset with every source requesting
    reset = 1'b1; adc_overrange = 1'b1; dac_overrange = 1'b1; pll_locked = 1'b0; tx_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_%0d", i), obs(), IDLE);
    end
    reset = 1'b0; adc_overrange = 1'b0; dac_overrange = 1'b0; pll_locked = 1'b1; tx_active = 1'b0;
    tick(); tick(); tick();
    check("idle_after_reset", obs(), IDLE);

    // 2: single-cycle ADC pulse, stretched through k+21
    adc_overrange = 1'b1;
    tick();
    adc_overrange = 1'b0;
    check("adc_pulse_k0", obs(), IDLE);
    for (int i = 1; i <= 23; i++) begin
      tick();
      check($sformatf("adc_pulse_k%0d", i), obs(), (i >= 2 && i <= 21) ? ADC : IDLE);
    end

    // 3: DAC blink, then ADC preempts
    dac_overrange = 1'b1;
    tick(); tick();
    check("dac_latency", obs(), IDLE);
    for (int j = 0; j < 12; j++) begin
      tick();
      check($sformatf("dac_blink_%0d", j), obs(), dac_pat(j));
    end
    adc_overrange = 1'b1;
    tick();
    adc_overrange = 1'b0;
    check("preempt_m0", obs(), dac_pat(12));
    tick();
    check("preempt_m1", obs(), dac_pat(13));
    for (int i = 2; i <= 5; i++) begin
      tick();
      check($sformatf("preempt_m%0d", i), obs(), ADC);
    end
    dac_overrange = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("idle_after_adc_dac", obs(), IDLE);

    // 4: short TX request stretched by the minimum hold
    tx_active = 1'b1;
    tick();
    check("tx_k0", obs(), IDLE);
    tick();
    tx_active = 1'b0;
    check("tx_k1", obs(), AMBER);
    for (int i = 2; i <= 7; i++) begin
      tick();
      check($sformatf("tx_k%0d", i), obs(), (i <= 5) ? AMBER : IDLE);
    end

    // 5: PLL beats TX, then hands over when lock returns
    pll_locked = 1'b0; tx_active = 1'b1;
    tick();
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("pll_alt_%0d", j), obs(), pll_pat(j));
    end
    pll_locked = 1'b1;
    tick();
    check("pll_release_1", obs(), pll_pat(10));
    tick();
    check("pll_release_2", obs(), AMBER);
    tx_active = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_after_tx", obs(), IDLE);

    // 6: periodic ADC pulses keep red solid, then reset mid-stream
    for (int i = 0; i < 100; i++) begin
      adc_overrange = ((i % 15) == 0);
      tick();
      adc_overrange = 1'b0;
      if (i >= 2) check($sformatf("adc_train_%0d", i), obs(), ADC);
    end
    reset = 1'b1; adc_overrange = 1'b1;
    tick();
    check("mid_reset_0", obs(), IDLE);
    tick();
    check("mid_reset_1", obs(), IDLE);
    reset = 1'b0; adc_overrange = 1'b0;
    tick(); tick(); tick();
    check("no_residual_stretch", obs(), IDLE);
    adc_overrange = 1'b1;
    tick();
    adc_overrange = 1'b0;
    check("new_after_reset_0", obs(), IDLE);
    tick();
    check("new_after_reset_1", obs(), IDLE);
    tick();
    check("new_after_reset_2", obs(), ADC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
